// File: rtl/bist_signature_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// bist_signature_analyzer_pkg
//   Shared definitions for the BIST signature analyzer slice:
//   - FSM state encoding of the analyzer (IDLE / COMPACT / DONE)
//   - default MISR polynomial, seed, golden signature and run length
//   Imported by the analyzer top.
// ---------------------------------------------------------------------------
package bist_signature_analyzer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_DONE    = 2'd2
   } bist_state_t;

   localparam int          DEF_W       = 16;
   localparam logic [15:0] DEF_POLY    = 16'h1021;
   localparam logic [15:0] DEF_SEED    = 16'hFFFF;
   localparam logic [15:0] DEF_GOLDEN  = 16'h0000;
   localparam int          DEF_NCYCLES = 650;

endpackage

// File: rtl/bist_signature_analyzer_misr.sv
// ---------------------------------------------------------------------------
// bist_misr
//   W-bit Galois multiple-input signature register (MSB-out feedback).
//   Kept free of analyzer specifics so the pattern generator can reuse it.
//
//   Ports
//     clk    in  1  rising-edge clock
//     reset  in  1  synchronous active-low reset, clears the register
//     load   in  1  load seed (priority over en)
//     seed   in  W  value loaded on load
//     en     in  1  compact one data word this cycle
//     data   in  W  word folded into the register when en=1
//     misr   out W  register contents
// ---------------------------------------------------------------------------
module bist_misr #(
   parameter int             W    = 16,
   parameter logic [W-1:0]   POLY = W'(16'h1021)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         en,
   input  logic [W-1:0] data,
   output logic [W-1:0] misr
);

   logic [W-1:0] feedback;
   logic [W-1:0] misr_next;

   // Bit shifted out of the MSB selects whether the taps are folded back in.
   always_comb begin
      feedback  = misr[W-1] ? POLY : '0;
      misr_next = {misr[W-2:0], 1'b0} ^ feedback ^ data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         misr <= '0;
      end else if (load) begin
         misr <= seed;
      end else if (en) begin
         misr <= misr_next;
      end
   end

endmodule

// File: rtl/bist_signature_analyzer.sv
// ---------------------------------------------------------------------------
// bist_signature_analyzer
//   Consumes the BIST controller's init / running / finish strobes, compacts
//   the CUT response words into a MISR signature, counts compacted cycles and
//   on finish registers a pass/fail verdict against GOLDEN / NCYCLES. The
//   verdict is held until the next init.
//
//   Optional feature macro: SIG_READOUT_EN
//     When defined, a rd_start pulse in DONE serially shifts a copy of the
//     signature out MSB-first on rd_data, qualified by rd_valid (W cycles).
//
//   Ports
//     clk        in  1  rising-edge clock
//     reset      in  1  synchronous active-low reset
//     init       in  1  start of run: load SEED, clear count and verdict
//     running    in  1  one response word per high cycle (COMPACT only)
//     finish     in  1  end of run: register the verdict (COMPACT only)
//     resp_data  in  W  CUT response word
//     busy       out 1  FSM in COMPACT
//     done       out 1  verdict valid (FSM in DONE)
//     pass       out 1  done and signature/count both matched
//     fail       out 1  done and not pass
//     rd_start   in  1  (SIG_READOUT_EN) start serial readout
//     rd_data    out 1  (SIG_READOUT_EN) serial signature bit
//     rd_valid   out 1  (SIG_READOUT_EN) rd_data qualifier
//     signature  out W  current MISR contents
//
//   Handshake: the controller strobes are plain qualifiers, no ready path;
//   rd_valid is a pure valid with no back-pressure - the consumer must take
//   one bit per cycle while it is high.
// ---------------------------------------------------------------------------
module bist_signature_analyzer
   import bist_signature_analyzer_pkg::*;
#(
   parameter int           W       = DEF_W,
   parameter logic [W-1:0] POLY    = W'(DEF_POLY),
   parameter logic [W-1:0] SEED    = W'(DEF_SEED),
   parameter logic [W-1:0] GOLDEN  = W'(DEF_GOLDEN),
   parameter int           NCYCLES = DEF_NCYCLES
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic         running,
   input  logic         finish,
   input  logic [W-1:0] resp_data,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         fail,
`ifdef SIG_READOUT_EN
   input  logic         rd_start,
   output logic         rd_data,
   output logic         rd_valid,
`endif
   output logic [W-1:0] signature
);

   // One spare bit beyond what NCYCLES needs so an overlong run saturates
   // above NCYCLES instead of wrapping back onto it.
   localparam int CW = $clog2(NCYCLES + 1) + 1;

   bist_state_t   state;
   logic [CW-1:0] count;
   logic          misr_load;
   logic          misr_en;
   logic          verdict_ok;

   // init wins over everything; a finish cycle drops its running sample.
   assign misr_load  = init;
   assign misr_en    = (state == ST_COMPACT) && running && !finish && !init;
   assign verdict_ok = (signature == GOLDEN) && (count == CW'(NCYCLES));

   bist_misr #(
      .W    (W),
      .POLY (POLY)
   ) u_misr (
      .clk   (clk),
      .reset (reset),
      .load  (misr_load),
      .seed  (SEED),
      .en    (misr_en),
      .data  (resp_data),
      .misr  (signature)
   );

   // FSM, cycle counter and registered verdict.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
         fail  <= 1'b0;
      end else if (init) begin
         state <= ST_COMPACT;
         count <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
         pass  <= 1'b0;
         fail  <= 1'b0;
      end else begin
         case (state)
            ST_COMPACT: begin
               if (finish) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= verdict_ok;
                  fail  <= !verdict_ok;
               end else if (running) begin
                  if (count != '1) begin
                     count <= count + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_DONE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SIG_READOUT_EN
   localparam int RW = $clog2(W + 1);

   logic [W-1:0]  rd_shift;
   logic [RW-1:0] rd_left;

   // rd_shift holds the bits not yet presented; rd_left counts them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_shift <= '0;
         rd_left  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= 1'b0;
      end else if (init) begin
         rd_shift <= '0;
         rd_left  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= 1'b0;
      end else if (rd_valid) begin
         if (rd_left == '0) begin
            rd_valid <= 1'b0;
            rd_data  <= 1'b0;
         end else begin
            rd_data  <= rd_shift[W-1];
            rd_shift <= {rd_shift[W-2:0], 1'b0};
            rd_left  <= rd_left - 1'b1;
         end
      end else if (rd_start && (state == ST_DONE)) begin
         rd_valid <= 1'b1;
         rd_data  <= signature[W-1];
         rd_shift <= {signature[W-2:0], 1'b0};
         rd_left  <= RW'(W - 1);
      end
   end
`endif

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// ---------------------------------------------------------------------------
// tb_bist_signature_analyzer
//   Three analyzer instances share the controller strobes; each gets its own
//   response stream and parameter set:
//     u0: SEED=0,      GOLDEN=0,      NCYCLES=650
//     u1: SEED=0x8000, GOLDEN=0x1021, NCYCLES=1
//     u2: SEED=0x0001, GOLDEN=0x0002, NCYCLES=1
//   A behavioural model tracks each instance; expected verdicts are queued
//   when finish is driven and compared when the verdict appears.
// ---------------------------------------------------------------------------
module tb_bist_signature_analyzer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        init;
   logic        running;
   logic        finish;
   logic [15:0] resp [3];
   logic [2:0]  busy, done, pass, fail;
   logic [15:0] sig [3];
`ifdef SIG_READOUT_EN
   logic        rd_start;
   logic [2:0]  rd_data, rd_valid;
`endif

   bist_signature_analyzer #(.W(16), .SEED(16'h0000), .GOLDEN(16'h0000), .NCYCLES(650)) u0 (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
      .resp_data(resp[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
`ifdef SIG_READOUT_EN
      .rd_start(rd_start), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
`endif
      .signature(sig[0]));

   bist_signature_analyzer #(.W(16), .SEED(16'h8000), .GOLDEN(16'h1021), .NCYCLES(1)) u1 (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
      .resp_data(resp[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
`ifdef SIG_READOUT_EN
      .rd_start(rd_start), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
`endif
      .signature(sig[1]));

   bist_signature_analyzer #(.W(16), .SEED(16'h0001), .GOLDEN(16'h0002), .NCYCLES(1)) u2 (
      .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
      .resp_data(resp[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fail(fail[2]),
`ifdef SIG_READOUT_EN
      .rd_start(rd_start), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]),
`endif
      .signature(sig[2]));

   // ---------------- model ----------------
   localparam logic [15:0] POLY = 16'h1021;
   logic [15:0] m_seed [3] = '{16'h0000, 16'h8000, 16'h0001};
   logic [15:0] m_gold [3] = '{16'h0000, 16'h1021, 16'h0002};
   int          m_ncyc [3] = '{650, 1, 1};
   int          m_cmax [3] = '{2047, 3, 3};   // all-ones of $clog2(N+1)+1 bits

   int          m_st   [3];                    // 0 idle, 1 compact, 2 done
   logic [15:0] m_misr [3];
   int          m_cnt  [3];
   logic        m_done [3];

   // scoreboard entry: {instance[1:0], pass, signature[15:0]}
   logic [18:0] exp_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
      logic [15:0] r;
      r = m << 1;
      if (m[15]) r = r ^ POLY;
      return r ^ d;
   endfunction

   // ---------------- driver ----------------
   // One clock of stimulus, then the model advances and outputs are checked
   // on the falling edge.
   task automatic cyc(input logic rs, input logic i, input logic r, input logic f,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
      logic [15:0] d [3];
      logic [18:0] e;
      logic        ok;
      d[0] = d0; d[1] = d1; d[2] = d2;
      reset = rs; init = i; running = r; finish = f;
      resp[0] = d0; resp[1] = d1; resp[2] = d2;
      for (int k = 0; k < 3; k++) begin
         if (rs && !i && f && m_st[k] == 1) begin
            ok = (m_misr[k] == m_gold[k]) && (m_cnt[k] == m_ncyc[k]);
            exp_q.push_back({k[1:0], ok, m_misr[k]});
         end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (!rs) begin
            m_st[k] = 0; m_misr[k] = 16'h0; m_cnt[k] = 0; m_done[k] = 1'b0;
         end else if (i) begin
            m_st[k] = 1; m_misr[k] = m_seed[k]; m_cnt[k] = 0; m_done[k] = 1'b0;
         end else if (m_st[k] == 1 && f) begin
            m_st[k] = 2; m_done[k] = 1'b1;
         end else if (m_st[k] == 1 && r) begin
            m_misr[k] = misr_step(m_misr[k], d[k]);
            if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("sig%0d", k), 32'(sig[k]), 32'(m_misr[k]));
         check_val($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_st[k] == 1));
         check_val($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
      end
      while (exp_q.size() > 0) begin
         int k;
         e = exp_q.pop_front();
         k = int'(e[18:17]);
         check_val($sformatf("pass%0d", k), 32'(pass[k]), 32'(e[16]));
         check_val($sformatf("fail%0d", k), 32'(fail[k]), 32'(!e[16]));
         check_val($sformatf("vsig%0d", k), 32'(sig[k]), 32'(e[15:0]));
      end
   endtask

   task automatic run_same(input int n, input logic [15:0] d);
      for (int j = 0; j < n; j++) cyc(1, 0, 1, 0, d, d, d);
   endtask

   // ---------------- sequence ----------------
   initial begin
      reset = 1'b0; init = 1'b0; running = 1'b0; finish = 1'b0;
      resp[0] = '0; resp[1] = '0; resp[2] = '0;
`ifdef SIG_READOUT_EN
      rd_start = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_misr[k] = '0; m_cnt[k] = 0; m_done[k] = 1'b0;
      end

      // reset state, with strobes active to show reset overrides them
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      check_val("rst_busy", 32'(busy[0]), 0);
      check_val("rst_done", 32'(done[0]), 0);
      check_val("rst_pf", 32'({pass[0], fail[0]}), 0);
      check_val("rst_sig", 32'(sig[0]), 0);

      // strobes outside COMPACT are ignored
      cyc(1, 0, 1, 1, 16'h1234, 16'h1234, 16'h1234);
      check_val("idle_done", 32'(done[0]), 0);

      // 650 zero words with zero seed -> pass
      cyc(1, 1, 0, 0, 0, 0, 0);
      run_same(650, 16'h0000);
      cyc(1, 0, 0, 1, 0, 0, 0);
      check_val("t1_sig", 32'(sig[0]), 32'h0000);
      check_val("t1_pass", 32'(pass[0]), 1);
      check_val("t1_fail", 32'(fail[0]), 0);
      // verdict holds; stray finish/running ignored in DONE
      cyc(1, 0, 1, 1, 16'hBEEF, 16'hBEEF, 16'hBEEF);
      check_val("t1_hold", 32'(pass[0]), 1);

      // 649 cycles: signature matches golden but count does not -> fail
      cyc(1, 1, 0, 0, 0, 0, 0);
      run_same(649, 16'h0000);
      cyc(1, 0, 0, 1, 0, 0, 0);
      check_val("t4_sig", 32'(sig[0]), 32'h0000);
      check_val("t4_fail", 32'(fail[0]), 1);

      // single-cycle runs on u1 / u2
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0003);
      cyc(1, 0, 0, 1, 0, 0, 0);
      check_val("t2_sig", 32'(sig[1]), 32'h1021);
      check_val("t2_pass", 32'(pass[1]), 1);
      check_val("t3_sig", 32'(sig[2]), 32'h0001);
      check_val("t3_fail", 32'(fail[2]), 1);

      // finish together with running: sample dropped, verdict on prior values
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0003);
      cyc(1, 0, 1, 1, 16'h5555, 16'h5555, 16'h5555);
      check_val("fr_pass", 32'(pass[1]), 1);
      check_val("fr_sig", 32'(sig[1]), 32'h1021);

      // init together with finish/running: init wins
      cyc(1, 1, 1, 1, 16'h7777, 16'h7777, 16'h7777);
      check_val("ip_sig", 32'(sig[1]), 32'h8000);
      check_val("ip_busy", 32'(busy[1]), 1);

      // reset mid-run at cycle 300
      cyc(1, 1, 0, 0, 0, 0, 0);
      for (int j = 0; j < 300; j++) begin
         logic [15:0] rv;
         rv = 16'($urandom_range(0, 65535));
         cyc(1, 0, 1, 0, rv, rv, rv);
      end
      cyc(0, 0, 1, 0, 16'hAAAA, 16'hAAAA, 16'hAAAA);
      check_val("t5_busy", 32'(busy[0]), 0);
      check_val("t5_sig", 32'(sig[0]), 0);
      check_val("t5_done", 32'(done[0]), 0);
      run_same(5, 16'hC3C3);
      check_val("t5_nosig", 32'(sig[0]), 0);

      // random runs: variable length, gaps, optional finish+running overlap
      for (int t = 0; t < 8; t++) begin
         int len;
         len = $urandom_range(1, 40);
         cyc(1, 1, 0, 0, 0, 0, 0);
         for (int j = 0; j < len; j++) begin
            cyc(1, 0, 1'($urandom_range(0, 1)), 0,
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)));
         end
         cyc(1, 0, 1'($urandom_range(0, 1)), 1, 16'($urandom_range(0, 65535)),
             16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
         cyc(1, 0, 0, 0, 0, 0, 0);
      end

`ifdef SIG_READOUT_EN
      begin
         logic [15:0] rpat;
         rpat = 16'hA5C3;
         cyc(1, 1, 0, 0, 0, 0, 0);
         cyc(1, 0, 1, 0, rpat, 0, 0);
         cyc(1, 0, 0, 1, 0, 0, 0);
         check_val("t6_sig", 32'(sig[0]), 32'hA5C3);
         rd_start = 1'b1;
         cyc(1, 0, 0, 0, 0, 0, 0);
         rd_start = 1'b0;
         for (int b = 15; b >= 0; b--) begin
            check_val($sformatf("rd_valid_b%0d", b), 32'(rd_valid[0]), 1);
            check_val($sformatf("rd_data_b%0d", b), 32'(rd_data[0]), 32'(rpat[b]));
            if (b == 8) rd_start = 1'b1;   // ignored while shifting
            cyc(1, 0, 0, 0, 0, 0, 0);
            rd_start = 1'b0;
         end
         check_val("rd_valid_end", 32'(rd_valid[0]), 0);
         check_val("rd_sig_keep", 32'(sig[0]), 32'hA5C3);
         // init aborts a shift in progress
         rd_start = 1'b1;
         cyc(1, 0, 0, 0, 0, 0, 0);
         rd_start = 1'b0;
         cyc(1, 1, 0, 0, 0, 0, 0);
         check_val("rd_abort", 32'(rd_valid[0]), 0);
      end
`endif

      check_val("q_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
